// File: rtl/input_buffer_ctrl.sv
// Sequencer for the activation input buffer: loads a tile into all row FIFOs in
// lockstep, streams it out on compute_go, then waits out the row skew and pulses done.
module input_buffer_ctrl #(
    parameter int SYS_ROWS   = 4,
    parameter int A_BITWIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_valid,
    input  logic [CNT_W-1:0]               cfg_rows,
    output logic                           cfg_ready,
    output logic                           cfg_err,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [SYS_ROWS*A_BITWIDTH-1:0] s_data,
    input  logic [SYS_ROWS-1:0]            s_keep,
    input  logic                           compute_go,
    output logic [SYS_ROWS-1:0]            buf_wr_en,
    output logic [SYS_ROWS*A_BITWIDTH-1:0] buf_wr_data,
    output logic                           buf_read,
    output logic                           busy,
    output logic                           loaded,
    output logic                           done
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;

    localparam int DRAIN_W = $clog2(SYS_ROWS + 1);

    logic [2:0]         state_reg, state_next;
    logic [CNT_W-1:0]   len_reg, len_next;
    logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [CNT_W-1:0]   rd_cnt_reg, rd_cnt_next;
    logic [DRAIN_W-1:0] drain_cnt_reg, drain_cnt_next;
    logic               go_pend_reg, go_pend_next;
    logic               done_reg, done_next;

    logic               cfg_ok;
    logic               beat;
    logic [CNT_W-1:0]   len_m1;

    assign cfg_ok = (cfg_rows != '0) && (cfg_rows <= CNT_W'(DEPTH));
    assign beat   = (state_reg == ST_LOAD) && s_valid;
    assign len_m1 = len_reg - CNT_W'(1);

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        beat_cnt_next  = beat_cnt_reg;
        rd_cnt_next    = rd_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        go_pend_next   = go_pend_reg;
        done_next      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cfg_valid && cfg_ok) begin
                    len_next      = cfg_rows;
                    beat_cnt_next = '0;
                    go_pend_next  = 1'b0;
                    state_next    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (compute_go) begin
                    go_pend_next = 1'b1;
                end
                if (beat) begin
                    beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    if (beat_cnt_reg == len_m1) begin
                        rd_cnt_next = '0;
                        // A go seen on the final beat skips WAIT entirely
                        state_next  = (go_pend_reg || compute_go) ? ST_STREAM : ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (compute_go) begin
                    rd_cnt_next = '0;
                    state_next  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                rd_cnt_next = rd_cnt_reg + CNT_W'(1);
                if (rd_cnt_reg == len_m1) begin
                    drain_cnt_next = '0;
                    state_next     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drain_cnt_next = drain_cnt_reg + DRAIN_W'(1);
                if (drain_cnt_reg == DRAIN_W'(SYS_ROWS - 1)) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            len_reg       <= '0;
            beat_cnt_reg  <= '0;
            rd_cnt_reg    <= '0;
            drain_cnt_reg <= '0;
            go_pend_reg   <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            beat_cnt_reg  <= beat_cnt_next;
            rd_cnt_reg    <= rd_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            go_pend_reg   <= go_pend_next;
            done_reg      <= done_next;
        end
    end

    // done is registered so it lands len+SYS_ROWS cycles after the first read
    assign done      = done_reg;
    assign cfg_ready = (state_reg == ST_IDLE);
    assign cfg_err   = !rst && (state_reg == ST_IDLE) && cfg_valid && !cfg_ok;
    assign s_ready   = (state_reg == ST_LOAD);
    assign busy      = (state_reg != ST_IDLE);
    assign loaded    = (state_reg == ST_WAIT);
    assign buf_read  = (state_reg == ST_STREAM);
    assign buf_wr_en = {SYS_ROWS{beat && !rst}};

    generate
        for (genvar gi = 0; gi < SYS_ROWS; gi++) begin : g_lane
            assign buf_wr_data[gi*A_BITWIDTH +: A_BITWIDTH] =
                s_keep[gi] ? s_data[gi*A_BITWIDTH +: A_BITWIDTH] : '0;
        end
    endgenerate

endmodule
